// File: rtl/gf2mz_loader.sv
// Serial-to-word loader for the GF(2^m)[z] multiplier: packs d coefficients per
// RAM word (slot 0 in the MSBs), zero-pads the tail word and pulses done.
module gf2mz_loader #(
  parameter int unsigned n = 47,
  parameter int unsigned m = 79,
  parameter int unsigned d = 3,
  localparam int unsigned WIDTH = m * d,
  localparam int unsigned DEPTH = (n + d - 1) / d,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [m-1:0]     in_data,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_do,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(n + 1);
  localparam int unsigned SW = (d > 1) ? $clog2(d) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE_LAST, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     coef_q, coef_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [AW-1:0]     word_q, word_d;
  logic [WIDTH-1:0]  pack_q, pack_d;
  logic              in_ready_d, mem_we_d, busy_d, done_d;
  logic [AW-1:0]     mem_addr_d;
  logic [WIDTH-1:0]  mem_do_d;
  logic [WIDTH-1:0]  filled;
  logic              accept, last_beat, slot_full;

  assign accept    = in_valid & in_ready;
  assign last_beat = (coef_q == CW'(n - 1));
  assign slot_full = (slot_q == SW'(d - 1));

  // Pack register with the incoming coefficient dropped into the current slot
  always_comb begin
    filled = pack_q;
    for (int j = 0; j < int'(d); j++) begin
      if (slot_q == SW'(j)) filled[WIDTH-1-j*m -: m] = in_data;
    end
  end

  // Next-state and registered-output logic. The final write (full or padded)
  // is launched on the last accept so done lands two cycles after it.
  always_comb begin
    state_d    = state_q;
    coef_d     = coef_q;
    slot_d     = slot_q;
    word_d     = word_q;
    pack_d     = pack_q;
    in_ready_d = in_ready;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr;
    mem_do_d   = mem_do;
    busy_d     = busy;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
        coef_d     = '0;
        slot_d     = '0;
        word_d     = '0;
        pack_d     = '0;
        // a start coinciding with the done pulse is dropped
        if (start && !done) begin
          state_d    = LOAD;
          in_ready_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      LOAD: begin
        if (accept) begin
          coef_d = coef_q + CW'(1);
          if (slot_full || last_beat) begin
            mem_we_d   = 1'b1;
            mem_addr_d = word_q;
            mem_do_d   = filled;
            pack_d     = '0;
            slot_d     = '0;
            word_d     = word_q + AW'(1);
          end else begin
            pack_d = filled;
            slot_d = slot_q + SW'(1);
          end
          if (last_beat) begin
            in_ready_d = 1'b0;
            state_d    = slot_full ? DONE : WRITE_LAST;
          end
        end
      end
      WRITE_LAST, DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      coef_q   <= '0;
      slot_q   <= '0;
      word_q   <= '0;
      pack_q   <= '0;
      in_ready <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_do   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      coef_q   <= coef_d;
      slot_q   <= slot_d;
      word_q   <= word_d;
      pack_q   <= pack_d;
      in_ready <= in_ready_d;
      mem_we   <= mem_we_d;
      mem_addr <= mem_addr_d;
      mem_do   <= mem_do_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_gf2mz_loader.sv
// Scoreboard bench for gf2mz_loader: drivers push expected RAM writes and done
// times, monitors pop and compare whenever the DUTs write or pulse done.
module tb_gf2mz_loader;

  localparam int NC = 47;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  logic         start, in_valid, in_ready, mem_we, busy, done;
  logic [78:0]  in_data;
  logic [3:0]   mem_addr;
  logic [236:0] mem_do;

  logic         s_start, s_valid, s_ready, s_we, s_busy, s_done;
  logic [78:0]  s_data;
  logic [0:0]   s_addr;
  logic [236:0] s_do;

  gf2mz_loader u_dut (
    .clk(clk), .rst_b(rst_b), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_do(mem_do), .busy(busy), .done(done)
  );

  gf2mz_loader #(.n(6), .m(79), .d(3)) u_small (
    .clk(clk), .rst_b(rst_b), .start(s_start), .in_valid(s_valid),
    .in_ready(s_ready), .in_data(s_data), .mem_we(s_we),
    .mem_addr(s_addr), .mem_do(s_do), .busy(s_busy), .done(s_done)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_we = 0;
  int s_n_we = 0;

  logic [78:0]  coefs [NC];
  logic [3:0]   ea_q [$];
  logic [236:0] ed_q [$];
  int           dn_q [$];
  logic [0:0]   s_ea_q [$];
  logic [236:0] s_ed_q [$];
  int           s_dn_q [$];
  logic [3:0]   ea;
  logic [236:0] ed;
  logic [0:0]   s_ea;
  logic [236:0] s_ed;
  int           dn;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic logic [236:0] word_of(input int w);
    logic [236:0] r;
    r = '0;
    for (int j = 0; j < 3; j++) begin
      if (3 * w + j < NC) r[236-j*79 -: 79] = coefs[3*w+j];
    end
    return r;
  endfunction

  // Monitor for the n=47 instance
  always @(negedge clk) begin
    if (rst_b) begin
      if (mem_we) begin
        n_we++;
        if (ea_q.size() == 0) begin
          n_checks++;
          $display("FAIL stray_write: got write at addr %0d, expected no write", mem_addr);
        end else begin
          ea = ea_q.pop_front();
          ed = ed_q.pop_front();
          check("write", {mem_addr, mem_do}, {ea, ed});
        end
      end
      if (done) begin
        if (dn_q.size() == 0) begin
          n_checks++;
          $display("FAIL stray_done: got done at cycle %0d, expected none", cyc);
        end else begin
          dn = dn_q.pop_front();
          check("done_time", 256'(cyc), 256'(dn));
          check("busy_at_done", {in_ready, busy}, 0);
        end
      end
    end
  end

  // Monitor for the n=6 instance
  always @(negedge clk) begin
    if (rst_b) begin
      if (s_we) begin
        s_n_we++;
        if (s_ea_q.size() == 0) begin
          n_checks++;
          $display("FAIL small_stray_write: got write at addr %0d, expected no write", s_addr);
        end else begin
          s_ea = s_ea_q.pop_front();
          s_ed = s_ed_q.pop_front();
          check("small_write", {s_addr, s_do}, {s_ea, s_ed});
        end
      end
      if (s_done) begin
        if (s_dn_q.size() == 0) begin
          n_checks++;
          $display("FAIL small_stray_done: got done at cycle %0d, expected none", cyc);
        end else begin
          dn = s_dn_q.pop_front();
          check("small_done_time", 256'(cyc), 256'(dn));
        end
      end
    end
  end

  // Called at a negedge; returns at a negedge where the next load may start at once.
  task automatic drive_load(input int n_acc, input bit gaps, input bit mid_start,
                            input bit done_start, input string tag);
    int i = 0;
    int guard = 0;
    int last_c = 0;
    int c;
    int we0;
    int nw;
    bit rdy;
    nw = (n_acc == NC) ? 16 : n_acc / 3;
    for (int w = 0; w < nw; w++) begin
      ea_q.push_back(4'(w));
      ed_q.push_back(word_of(w));
    end
    we0 = n_we;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_ready_on"}, {busy, in_ready}, 2'b11);
    while (i < n_acc && guard < 4000) begin
      guard++;
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = coefs[i];
      start    = mid_start && (i == 10);
      rdy = in_ready;
      c   = cyc;
      @(posedge clk);
      if (in_valid && rdy) begin
        last_c = c;
        i++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (i < n_acc) begin
      n_checks++;
      $display("FAIL %s_timeout: got %0d accepts, expected %0d", tag, i, n_acc);
      return;
    end
    if (n_acc < NC) return;
    dn_q.push_back(last_c + 2);
    check({tag, "_ready_off"}, in_ready, 0);
    @(negedge clk);
    start = done_start;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_idle_after"}, {busy, in_ready}, 0);
    check({tag, "_we_count"}, 256'(n_we - we0), 256'(nw));
  endtask

  task automatic small_load();
    int i = 0;
    int guard = 0;
    int last_c = 0;
    int c;
    bit rdy;
    logic [78:0] v;
    s_ea_q.push_back(1'b0);
    s_ed_q.push_back({79'hA, 79'hB, 79'hC});
    s_ea_q.push_back(1'b1);
    s_ed_q.push_back({79'hD, 79'hE, 79'hF});
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    while (i < 6 && guard < 100) begin
      guard++;
      v = 79'(10 + i);
      s_valid = 1'b1;
      s_data  = v;
      rdy = s_ready;
      c   = cyc;
      @(posedge clk);
      if (rdy) begin
        last_c = c;
        i++;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    if (i < 6) begin
      n_checks++;
      $display("FAIL small_timeout: got %0d accepts, expected 6", i);
      return;
    end
    s_dn_q.push_back(last_c + 2);
    check("small_ready_off", s_ready, 0);
    repeat (2) @(negedge clk);
    check("small_we_count", 256'(s_n_we), 256'(2));
  endtask

  initial begin
    start = 1'b0; in_valid = 1'b0; in_data = '0;
    s_start = 1'b0; s_valid = 1'b0; s_data = '0;
    @(negedge clk);
    check("reset_vals", {in_ready, mem_we, mem_addr, mem_do, busy, done}, 0);
    check("small_reset_vals", {s_ready, s_we, s_addr, s_do, s_busy, s_done}, 0);
    rst_b = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NC; i++) coefs[i] = 79'(i + 1);
    drive_load(NC, 1'b0, 1'b0, 1'b0, "full");

    small_load();

    // Valid asserted while idle must not be consumed or raise ready
    in_valid = 1'b1;
    in_data  = '1;
    repeat (4) begin
      @(negedge clk);
      check("idle_ignores_valid", {in_ready, busy, mem_we}, 0);
    end
    in_valid = 1'b0;

    drive_load(NC, 1'b1, 1'b1, 1'b1, "gaps");

    for (int i = 0; i < NC; i++) coefs[i] = 79'(i + 501);
    drive_load(20, 1'b0, 1'b0, 1'b0, "abort");
    #2 rst_b = 1'b0;
    #1 check("async_reset", {in_ready, mem_we, mem_addr, mem_do, busy, done}, 0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NC; i++) coefs[i] = 79'(i + 201);
    drive_load(NC, 1'b0, 1'b0, 1'b0, "reload");

    for (int i = 0; i < NC; i++) coefs[i] = 79'(i + 301);
    drive_load(NC, 1'b0, 1'b0, 1'b0, "b2b_first");
    for (int i = 0; i < NC; i++) coefs[i] = {40'h5A5A5A5A5A, 39'(i + 1001)};
    drive_load(NC, 1'b0, 1'b0, 1'b0, "b2b_second");

    repeat (4) @(negedge clk);
    check("queues_drained", 256'(ea_q.size() + dn_q.size() + s_ea_q.size() + s_dn_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
